// File: rtl/image_seq_pkg.sv
// Shared types for the camera-frame / touch sequencer: FSM states, calibration modes,
// default coordinate width and a saturating counter helper.
package image_seq_pkg;

    localparam int CW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EVAL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        CAL_TL = 2'd1,
        CAL_BR = 2'd2
    } mode_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/frame_debounce.sv
// Consecutive-touch-frame counter with lift (released) tracking; accept_o is combinational
// in the eval cycle. calib_i outranks everything and demands a lift before the next accept.
module frame_debounce
    import image_seq_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic calib_i,
    input  logic flush_i,
    input  logic eval_i,
    input  logic touch_i,
    output logic accept_o
);

    localparam int NW = $clog2(STABLE_FRAMES + 1);
    localparam logic [NW-1:0] CNT_MAX  = NW'(STABLE_FRAMES);
    localparam logic [NW-1:0] CNT_LAST = NW'(STABLE_FRAMES - 1);

    logic [NW-1:0] count_q, count_d;
    logic          released_q, released_d;

    always_comb begin
        count_d    = count_q;
        released_d = released_q;
        accept_o   = 1'b0;
        if (calib_i) begin
            count_d    = '0;
            released_d = 1'b0;
        end else if (flush_i) begin
            count_d = '0;
        end else if (eval_i) begin
            if (touch_i) begin
                if (count_q != CNT_MAX) count_d = count_q + 1'b1;
                // Only the frame that completes the run may accept; longer holds stay silent.
                if (count_q == CNT_LAST && released_q) begin
                    accept_o   = 1'b1;
                    released_d = 1'b0;
                end
            end else begin
                count_d    = '0;
                released_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q    <= '0;
            released_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            released_q <= released_d;
        end
    end

endmodule

// File: rtl/touch_calib_sequencer.sv
// Frame-level controller for image_process: one frame_available per frame (2 cycles after tick), debounced
// touches and two-corner calibration. TOUCH_AVG_EN averages each accepted touch with the previous one.
module touch_calib_sequencer
    import image_seq_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 1024,
    parameter int CW            = CW_DEF
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          frame_tick_i,
    input  logic          calib_req_i,
    input  logic          raw_sel_i,
    input  logic          touch_i,
    input  logic          touch_ready_i,
    input  logic [CW-1:0] touch_h_i,
    input  logic [CW-1:0] touch_v_i,
    output logic          frame_available_o,
    output logic          display_raw_o,
    output logic          blank_frame_o,
    output logic          write_top_left_o,
    output logic          write_bottom_right_o,
    output logic          calib_done_o,
    output logic          touch_valid_o,
    output logic [CW-1:0] touch_x_o,
    output logic [CW-1:0] touch_y_o,
    output logic [7:0]    overrun_cnt_o
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          pending_q, pending_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          smp_touch_q;
    logic [CW-1:0] smp_h_q, smp_v_q;
    logic          fa_q, fa_d;
    logic          raw_q, raw_d;
    logic          done_q, done_d;
    logic          tv_q, tv_d;
    logic          wtl_q, wtl_d;
    logic          wbr_q, wbr_d;
    logic [CW-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          eval, tmo_hit, drop, accept;
    logic [CW-1:0] new_x, new_y;

    frame_debounce #(.STABLE_FRAMES(STABLE_FRAMES)) u_debounce (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .calib_i  (calib_req_i),
        .flush_i  (tmo_hit),
        .eval_i   (eval),
        .touch_i  (smp_touch_q),
        .accept_o (accept)
    );

`ifdef TOUCH_AVG_EN
    logic          have_prev_q;
    logic [CW:0]   sum_x, sum_y;
    assign sum_x = {1'b0, tx_q} + {1'b0, smp_h_q};
    assign sum_y = {1'b0, ty_q} + {1'b0, smp_v_q};
    assign new_x = have_prev_q ? sum_x[CW:1] : smp_h_q;
    assign new_y = have_prev_q ? sum_y[CW:1] : smp_v_q;

    // Averaging history restarts after reset and after each completed calibration.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)  have_prev_q <= 1'b0;
        else if (wbr_d) have_prev_q <= 1'b0;
        else if (tv_d)  have_prev_q <= 1'b1;
    end
`else
    assign new_x = smp_h_q;
    assign new_y = smp_v_q;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tmo_d     = tmo_q;
        fa_d      = 1'b0;
        eval      = 1'b0;
        tmo_hit   = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: if (frame_tick_i || pending_q) begin
                state_d   = REQ;
                pending_d = 1'b0;
            end
            REQ: begin
                fa_d    = 1'b1;
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (touch_ready_i) begin
                state_d = EVAL;
            end else if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            EVAL: begin
                eval    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // One frame may queue while busy; anything beyond that is lost.
        if (frame_tick_i && state_q != IDLE) begin
            if (pending_q) drop = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        done_d = done_q;
        tv_d   = 1'b0;
        wtl_d  = 1'b0;
        wbr_d  = 1'b0;
        tx_d   = tx_q;
        ty_d   = ty_q;
        if (calib_req_i) begin
            mode_d = CAL_TL;
            done_d = 1'b0;
        end else if (accept) begin
            case (mode_q)
                CAL_TL: begin
                    wtl_d  = 1'b1;
                    mode_d = CAL_BR;
                end
                CAL_BR: begin
                    wbr_d  = 1'b1;
                    mode_d = NORMAL;
                    done_d = 1'b1;
                end
                default: begin
                    tv_d = 1'b1;
                    tx_d = new_x;
                    ty_d = new_y;
                end
            endcase
        end
        raw_d = raw_sel_i && (mode_d == NORMAL);
        ovr_d = sat_add8(ovr_q, {1'b0, drop} + {1'b0, tmo_hit});
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            mode_q      <= NORMAL;
            pending_q   <= 1'b0;
            tmo_q       <= '0;
            smp_touch_q <= 1'b0;
            smp_h_q     <= '0;
            smp_v_q     <= '0;
            fa_q        <= 1'b0;
            raw_q       <= 1'b0;
            done_q      <= 1'b0;
            tv_q        <= 1'b0;
            wtl_q       <= 1'b0;
            wbr_q       <= 1'b0;
            tx_q        <= '0;
            ty_q        <= '0;
            ovr_q       <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            tmo_q     <= tmo_d;
            if (state_q == WAIT && touch_ready_i) begin
                smp_touch_q <= touch_i;
                smp_h_q     <= touch_h_i;
                smp_v_q     <= touch_v_i;
            end
            fa_q   <= fa_d;
            raw_q  <= raw_d;
            done_q <= done_d;
            tv_q   <= tv_d;
            wtl_q  <= wtl_d;
            wbr_q  <= wbr_d;
            tx_q   <= tx_d;
            ty_q   <= ty_d;
            ovr_q  <= ovr_d;
        end
    end

    assign frame_available_o    = fa_q;
    assign display_raw_o        = raw_q;
    assign blank_frame_o        = (mode_q != NORMAL);
    assign write_top_left_o     = wtl_q;
    assign write_bottom_right_o = wbr_q;
    assign calib_done_o         = done_q;
    assign touch_valid_o        = tv_q;
    assign touch_x_o            = tx_q;
    assign touch_y_o            = ty_q;
    assign overrun_cnt_o        = ovr_q;

endmodule

// File: tb/tb_touch_calib_sequencer.sv
// Randomised bench for touch_calib_sequencer: a behavioural touch/calibration model queues expected
// pulses, a forked monitor pops and compares them whenever the DUT emits a pulse.
module tb_touch_calib_sequencer;

    localparam int STABLE = 3;
    localparam int TMO    = 16;

    typedef struct packed {
        logic [2:0] kind;   // 4 = touch_valid, 2 = write_top_left, 1 = write_bottom_right
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic       clock, reset;
    logic       frame_tick, calib_req, raw_sel, touch, touch_ready;
    logic [9:0] touch_h, touch_v;
    logic       frame_available, display_raw, blank_frame;
    logic       write_top_left, write_bottom_right, calib_done, touch_valid;
    logic [9:0] touch_x, touch_y;
    logic [7:0] overrun_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference model state
    int m_run, m_mode, m_x, m_y, m_ov;
    bit m_lifted, m_done, m_prev;

    touch_calib_sequencer #(.STABLE_FRAMES(STABLE), .TIMEOUT(TMO), .CW(10)) dut (
        .clock_i              (clock),
        .reset_ni             (reset),
        .frame_tick_i         (frame_tick),
        .calib_req_i          (calib_req),
        .raw_sel_i            (raw_sel),
        .touch_i              (touch),
        .touch_ready_i        (touch_ready),
        .touch_h_i            (touch_h),
        .touch_v_i            (touch_v),
        .frame_available_o    (frame_available),
        .display_raw_o        (display_raw),
        .blank_frame_o        (blank_frame),
        .write_top_left_o     (write_top_left),
        .write_bottom_right_o (write_bottom_right),
        .calib_done_o         (calib_done),
        .touch_valid_o        (touch_valid),
        .touch_x_o            (touch_x),
        .touch_y_o            (touch_y),
        .overrun_cnt_o        (overrun_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_x = 0; m_y = 0; m_ov = 0;
        m_lifted = 1'b1; m_done = 1'b0; m_prev = 1'b0;
    endtask

    // A touch is accepted on the STABLE-th consecutive touch frame, provided the finger was lifted since the last accept.
    task automatic model_frame(input bit t, input int h, input int v);
        exp_t e;
        int   ex, ey;
        if (!t) begin
            m_run = 0;
            m_lifted = 1'b1;
        end else begin
            m_run++;
            if (m_run == STABLE && m_lifted) begin
                m_lifted = 1'b0;
                if (m_mode == 0) begin
                    ex = h; ey = v;
`ifdef TOUCH_AVG_EN
                    if (m_prev) begin ex = (m_x + h) / 2; ey = (m_y + v) / 2; end
`endif
                    m_prev = 1'b1; m_x = ex; m_y = ey;
                    e.kind = 3'd4; e.x = ex[9:0]; e.y = ey[9:0];
                end else if (m_mode == 1) begin
                    m_mode = 2;
                    e.kind = 3'd2; e.x = '0; e.y = '0;
                end else begin
                    m_mode = 0; m_done = 1'b1; m_prev = 1'b0;
                    e.kind = 3'd1; e.x = '0; e.y = '0;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (touch_valid || write_top_left || write_bottom_right)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {touch_valid, write_top_left, write_bottom_right}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {touch_valid, write_top_left, write_bottom_right}, e.kind);
                    if (e.kind == 3'd4) begin
                        check("touch_x", touch_x, e.x);
                        check("touch_y", touch_y, e.y);
                    end
                end
            end
        end
    endtask

    task automatic tick_and_wait(output int k);
        @(negedge clock);
        frame_tick = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) frame_tick = 1'b0;
        end while (!frame_available && k < 20);
        if (!frame_available) check("frame_available_seen", frame_available, 1);
    endtask

    task automatic wait_fa();
        int n = 0;
        while (!frame_available && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("pending_serviced", frame_available, 1);
    endtask

    task automatic respond(input bit t, input int h, input int v);
        repeat ($urandom_range(0, 4)) @(negedge clock);
        touch_ready = 1'b1; touch = t; touch_h = h[9:0]; touch_v = v[9:0];
        model_frame(t, h, v);
        @(negedge clock);
        touch_ready = 1'b0; touch = 1'b0; touch_h = 10'($urandom); touch_v = 10'($urandom);
        repeat (2) @(negedge clock);
    endtask

    task automatic post_checks();
        check("blank_frame", blank_frame, (m_mode != 0));
        check("calib_done", calib_done, m_done);
        check("display_raw", display_raw, (raw_sel && m_mode == 0));
    endtask

    task automatic frame(input bit t, input int h, input int v);
        int k;
        tick_and_wait(k);
        check("fa_latency", k, 2);
        respond(t, h, v);
        post_checks();
    endtask

    task automatic do_calib();
        @(negedge clock); calib_req = 1'b1;
        @(negedge clock); calib_req = 1'b0;
        m_mode = 1; m_done = 1'b0; m_run = 0; m_lifted = 1'b0;
        check("calib_blank", blank_frame, 1);
        check("calib_done_clr", calib_done, 0);
    endtask

    initial begin
        int k, extra;
        logic [34:0] outs;
        reset = 1'b0; frame_tick = 1'b0; calib_req = 1'b0; raw_sel = 1'b0;
        touch = 1'b0; touch_ready = 1'b0; touch_h = '0; touch_v = '0;
        model_reset();
        fork monitor(); join_none

        repeat (3) @(negedge clock);
        outs = {frame_available, display_raw, blank_frame, write_top_left, write_bottom_right,
                calib_done, touch_valid, touch_x, touch_y, overrun_cnt};
        check("reset_outputs", outs, 0);
        reset = 1'b1;
        @(negedge clock);

        // Debounce: one accept on the 3rd frame, none on the 4th; lift, then a second touch
        for (int i = 0; i < 4; i++) frame(1'b1, 100, 50);
        frame(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) frame(1'b1, 200, 150);

        // Two-corner calibration
        do_calib();
        for (int i = 0; i < 3; i++) frame(1'b1, 20, 15);
        frame(1'b0, 0, 0);
        for (int i = 0; i < 3; i++) frame(1'b1, 600, 460);

        // Timeout: IDLE and overrun exactly TMO cycles after frame_available
        tick_and_wait(k);
        check("fa_latency_tmo", k, 2);
        repeat (TMO - 1) @(negedge clock);
        check("tmo_not_yet", overrun_cnt, m_ov);
        @(negedge clock);
        m_ov++; m_run = 0;
        check("tmo_overrun", overrun_cnt, m_ov);
        touch_ready = 1'b1; touch = 1'b1;
        @(negedge clock);
        touch_ready = 1'b0; touch = 1'b0;
        repeat (3) @(negedge clock);
        frame(1'b0, 0, 0);

        // Overrun: three ticks during WAIT -> one pending request, two drops
        tick_and_wait(k);
        check("fa_latency_ovr", k, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); frame_tick = 1'b1;
            @(negedge clock); frame_tick = 1'b0;
        end
        m_ov += 2;
        respond(1'b1, 300, 200);
        wait_fa();
        respond(1'b1, 310, 210);
        extra = 0;
        repeat (8) begin
            @(negedge clock);
            if (frame_available) extra++;
        end
        check("no_extra_request", extra, 0);
        check("overrun_cnt", overrun_cnt, m_ov);

        // Asynchronous reset in the middle of WAIT
        tick_and_wait(k);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        outs = {frame_available, display_raw, blank_frame, write_top_left, write_bottom_right,
                calib_done, touch_valid, touch_x, touch_y, overrun_cnt};
        check("async_reset_outputs", outs, 0);
        model_reset();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        frame(1'b0, 0, 0);

        // Random frames with occasional calibration requests
        for (int i = 0; i < 80; i++) begin
            raw_sel = 1'($urandom);
            if ($urandom_range(0, 11) == 0) do_calib();
            frame(($urandom_range(0, 3) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end

        repeat (10) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
